serial_frame_capture: RTL and testbench

- Downstream consumer of the single-bit registered stream produced by the capture stage's `out` flop.
- Hunts for a sync pattern in the serial bitstream, then deserializes a fixed-length frame of MSB-first words.
- Buffers the words in a small FIFO and presents them on a valid/ready word interface to the parallel datapath.

---
 rtl/serial_frame_capture.sv | 198 +++++++++++++++++++
 tb/tb_serial_frame_capture.sv | 228 ++++++++++++++++++++++
 2 files changed

// File: rtl/serial_frame_capture.sv
// serial_frame_capture
//   Hunts for a sync pattern in a single-bit serial stream, then deserializes
//   a fixed-length frame of MSB-first words into a small output FIFO that is
//   drained through a valid/ready word interface.
//
// Ports
//   clk         rising-edge clock for all state
//   rst_n       asynchronous active-low reset (clears FIFO and all counters)
//   din         serial data bit
//   en          din is accepted on edges where en=1
//   dout        FIFO head word (0 while the FIFO is empty)
//   dout_valid  FIFO not empty
//   dout_ready  consumer accepts the head word (pop = dout_valid & dout_ready)
//   locked      high while collecting frame data
//   frame_done  one-cycle pulse after the last word of a frame is captured
//   overflow    sticky: a completed word was dropped because the FIFO was full
//   clr_ovf     synchronous clear of overflow (a same-cycle drop wins)
module serial_frame_capture #(
  parameter int                SYNC_W      = 8,
  parameter logic [SYNC_W-1:0] SYNC_PAT    = 8'hA5,
  parameter int                WORD_W      = 8,
  parameter int                FRAME_WORDS = 4,
  parameter int                FIFO_DEPTH  = 4
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              din,
  input  logic              en,
  output logic [WORD_W-1:0] dout,
  output logic              dout_valid,
  input  logic              dout_ready,
  output logic              locked,
  output logic              frame_done,
  output logic              overflow,
  input  logic              clr_ovf
);

  localparam int AW  = $clog2(FIFO_DEPTH);
  localparam int HCW = $clog2(SYNC_W + 1);
  localparam int BCW = (WORD_W > 1) ? $clog2(WORD_W) : 1;
  localparam int FCW = (FRAME_WORDS > 1) ? $clog2(FRAME_WORDS) : 1;

  typedef enum logic [0:0] {HUNT, COLLECT} state_t;

  state_t state_reg, state_next;

  // Only the low SYNC_W-1 / WORD_W-1 bits of the shift registers are ever
  // needed: the oldest bit falls out on the very edge that completes a
  // pattern or word, so it is never stored.
  logic [SYNC_W-2:0] sync_sh_reg;
  logic [SYNC_W-1:0] sync_shifted;
  logic [HCW-1:0]    hunt_cnt_reg;
  logic [WORD_W-2:0] word_sh_reg;
  logic [WORD_W-1:0] word_done;
  logic [BCW-1:0]    bit_cnt_reg;
  logic [FCW-1:0]    word_cnt_reg;
  logic              frame_done_reg;
  logic              overflow_reg;

  logic [WORD_W-1:0] mem [FIFO_DEPTH];
  logic [AW:0]       wr_ptr_reg;
  logic [AW:0]       rd_ptr_reg;

  logic accept_hunt;
  logic accept_collect;
  logic match;
  logic word_last;
  logic frame_last;
  logic fifo_full;
  logic fifo_empty;
  logic pop;
  logic push_ok;
  logic drop;

  // ---------------------------------------------------------------- FSM
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_reg <= HUNT;
    end else begin
      state_reg <= state_next;
    end
  end

  always_comb begin
    state_next     = state_reg;
    match          = 1'b0;
    word_last      = 1'b0;
    frame_last     = 1'b0;
    accept_hunt    = en && (state_reg == HUNT);
    accept_collect = en && (state_reg == COLLECT);
    sync_shifted   = {sync_sh_reg, din};
    word_done      = {word_sh_reg, din};
    case (state_reg)
      HUNT: begin
        // hunt_cnt >= SYNC_W-1 means this bit is at least the SYNC_W-th one
        // since entering HUNT, so the window holds no stale zeros.
        if (accept_hunt && (sync_shifted == SYNC_PAT) &&
            (hunt_cnt_reg >= HCW'(SYNC_W - 1))) begin
          match      = 1'b1;
          state_next = COLLECT;
        end
      end
      COLLECT: begin
        if (accept_collect && (bit_cnt_reg == BCW'(WORD_W - 1))) begin
          word_last = 1'b1;
          if (word_cnt_reg == FCW'(FRAME_WORDS - 1)) begin
            frame_last = 1'b1;
            state_next = HUNT;
          end
        end
      end
      default: state_next = HUNT;
    endcase
  end

  // ------------------------------------------------------ shift/counters
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sync_sh_reg    <= '0;
      hunt_cnt_reg   <= '0;
      word_sh_reg    <= '0;
      bit_cnt_reg    <= '0;
      word_cnt_reg   <= '0;
      frame_done_reg <= 1'b0;
    end else begin
      frame_done_reg <= frame_last;
      if (accept_hunt) begin
        sync_sh_reg <= sync_shifted[SYNC_W-2:0];
        if (hunt_cnt_reg != HCW'(SYNC_W)) begin
          hunt_cnt_reg <= hunt_cnt_reg + HCW'(1);
        end
      end
      if (match) begin
        bit_cnt_reg  <= '0;
        word_cnt_reg <= '0;
      end
      if (accept_collect) begin
        word_sh_reg <= word_done[WORD_W-2:0];
        if (word_last) begin
          bit_cnt_reg  <= '0;
          word_cnt_reg <= frame_last ? '0 : word_cnt_reg + FCW'(1);
        end else begin
          bit_cnt_reg <= bit_cnt_reg + BCW'(1);
        end
      end
      // Restart the hunt from a clean window so sync never spans frame data.
      if (frame_last) begin
        sync_sh_reg  <= '0;
        hunt_cnt_reg <= '0;
      end
    end
  end

  // ---------------------------------------------------------------- FIFO
  assign fifo_empty = (wr_ptr_reg == rd_ptr_reg);
  assign fifo_full  = (wr_ptr_reg[AW] != rd_ptr_reg[AW]) &&
                      (wr_ptr_reg[AW-1:0] == rd_ptr_reg[AW-1:0]);
  assign pop        = !fifo_empty && dout_ready;
  // A full FIFO still accepts a word when the head leaves on the same edge;
  // the write then lands in the slot being vacated.
  assign push_ok    = word_last && (!fifo_full || pop);
  assign drop       = word_last && fifo_full && !pop;

  always_ff @(posedge clk) begin
    if (push_ok) begin
      mem[wr_ptr_reg[AW-1:0]] <= word_done;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr_reg   <= '0;
      rd_ptr_reg   <= '0;
      overflow_reg <= 1'b0;
    end else begin
      if (push_ok) begin
        wr_ptr_reg <= wr_ptr_reg + (AW+1)'(1);
      end
      if (pop) begin
        rd_ptr_reg <= rd_ptr_reg + (AW+1)'(1);
      end
      if (drop) begin
        overflow_reg <= 1'b1;
      end else if (clr_ovf) begin
        overflow_reg <= 1'b0;
      end
    end
  end

  // Head word is gated so dout reads 0 whenever nothing is buffered,
  // including straight out of reset when the storage is uninitialised.
  assign dout       = fifo_empty ? '0 : mem[rd_ptr_reg[AW-1:0]];
  assign dout_valid = !fifo_empty;
  assign locked     = (state_reg == COLLECT);
  assign frame_done = frame_done_reg;
  assign overflow   = overflow_reg;

endmodule

// File: tb/tb_serial_frame_capture.sv
module tb_serial_frame_capture;

  logic       clk = 1'b0;
  logic       rst_n;
  logic       din;
  logic       en;
  logic [7:0] dout;
  logic       dout_valid;
  logic       dout_ready;
  logic       locked;
  logic       frame_done;
  logic       overflow;
  logic       clr_ovf;

  int         checks   = 0;
  int         failures = 0;
  logic [7:0] sb [$];

  serial_frame_capture dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .din        (din),
    .en         (en),
    .dout       (dout),
    .dout_valid (dout_valid),
    .dout_ready (dout_ready),
    .locked     (locked),
    .frame_done (frame_done),
    .overflow   (overflow),
    .clr_ovf    (clr_ovf)
  );

  always #5 clk = ~clk;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
    checks++;
    if (act !== req) begin
      failures++;
      $display("FAIL %s actual=%0h required=%0h", name, act, req);
    end
  endtask

  // Monitor: every accepted word is compared with the scoreboard head.
  always @(negedge clk) begin
    if (rst_n === 1'b1 && dout_valid === 1'b1 && dout_ready === 1'b1) begin
      if (sb.size() == 0) begin
        checks++;
        failures++;
        $display("FAIL word_unexpected actual=%0h required=none", dout);
      end else begin
        logic [7:0] exp_w;
        exp_w = sb.pop_front();
        $display("pop dout=%02h expected=%02h", dout, exp_w);
        check("word", {24'h0, dout}, {24'h0, exp_w});
      end
    end
  end

  // Inputs change 1 time unit after the rising edge; outputs are read there too.
  task automatic send_bit(input logic b, input logic e);
    din = b;
    en  = e;
    @(posedge clk);
    #1;
  endtask

  // MSB first; with toggle, an en=0 cycle with a random bit precedes each bit.
  task automatic send_byte(input logic [7:0] w, input bit toggle);
    for (int i = 7; i >= 0; i--) begin
      if (toggle) send_bit(1'($urandom_range(1)), 1'b0);
      send_bit(w[i], 1'b1);
    end
  endtask

  task automatic send_sync(input bit toggle);
    send_byte(8'hA5, toggle);
    check("locked_after_sync", {31'h0, locked}, 32'h1);
  endtask

  task automatic send_words(input logic [31:0] f, input bit toggle, input bit lat_chk);
    for (int k = 0; k < 4; k++) begin
      logic [7:0] w;
      w = f[31 - 8*k -: 8];
      send_byte(w, toggle);
      if (lat_chk) begin
        check("lat_valid", {31'h0, dout_valid}, 32'h1);
        check("lat_dout", {24'h0, dout}, {24'h0, w});
      end
    end
    check("frame_done_pulse", {31'h0, frame_done}, 32'h1);
    check("unlocked_at_end", {31'h0, locked}, 32'h0);
    send_bit(1'b0, 1'b0);
    check("frame_done_single", {31'h0, frame_done}, 32'h0);
  endtask

  task automatic expect_frame(input logic [31:0] f);
    for (int k = 0; k < 4; k++) sb.push_back(f[31 - 8*k -: 8]);
  endtask

  task automatic wait_drain(input int max_cycles);
    for (int i = 0; i < max_cycles && sb.size() != 0; i++) @(negedge clk);
    @(posedge clk);
    #1;
    check("drain", sb.size(), 0);
  endtask

  // Bits 1,0,1 then A5; the first full-window match is the 11th bit.
  logic [10:0] hunt_bits = 11'b101_1010_0101;

  initial begin
    #2_000_000;
    $display("FAIL timeout actual=running required=finished");
    $fatal(1, "timeout");
  end

  initial begin
    rst_n = 1'b0; din = 1'b0; en = 1'b0; dout_ready = 1'b0; clr_ovf = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    check("rst_dout", {24'h0, dout}, 32'h0);
    check("rst_valid", {31'h0, dout_valid}, 32'h0);
    check("rst_locked", {31'h0, locked}, 32'h0);
    check("rst_frame_done", {31'h0, frame_done}, 32'h0);
    check("rst_overflow", {31'h0, overflow}, 32'h0);
    rst_n = 1'b1;
    send_bit(1'b0, 1'b0);

    // Test 1: basic frame.
    $display("test1 basic frame");
    dout_ready = 1'b1;
    expect_frame(32'h12345678);
    for (int i = 7; i >= 1; i--) send_bit(1'(8'hA5 >> i), 1'b1);
    check("no_lock_at_bit7", {31'h0, locked}, 32'h0);
    send_bit(1'b1, 1'b1);
    check("lock_at_bit8", {31'h0, locked}, 32'h1);
    send_words(32'h12345678, 1'b0, 1'b1);
    wait_drain(10);

    // Test 2: preamble with overlap, lock only at the first full-window match.
    $display("test2 hunt with preamble");
    for (int i = 10; i >= 0; i--) begin
      send_bit(hunt_bits[i], 1'b1);
      check("hunt_lock", {31'h0, locked}, (i == 0) ? 32'h1 : 32'h0);
    end
    expect_frame(32'hDEADBEEF);
    send_words(32'hDEADBEEF, 1'b0, 1'b1);
    wait_drain(10);

    // Test 3: en toggling, identical output words.
    $display("test3 en toggling");
    expect_frame(32'h12345678);
    send_sync(1'b1);
    send_words(32'h12345678, 1'b1, 1'b1);
    wait_drain(10);

    // Test 4: two frames with ready low, second frame dropped.
    $display("test4 overflow");
    dout_ready = 1'b0;
    expect_frame(32'h12345678);
    send_sync(1'b0);
    send_words(32'h12345678, 1'b0, 1'b0);
    check("no_ovf_first_frame", {31'h0, overflow}, 32'h0);
    send_sync(1'b0);
    send_words(32'h9ABCDEF0, 1'b0, 1'b0);
    check("ovf_set", {31'h0, overflow}, 32'h1);
    check("hold_valid", {31'h0, dout_valid}, 32'h1);
    check("hold_dout", {24'h0, dout}, 32'h12);
    dout_ready = 1'b1;
    wait_drain(20);
    check("drained_valid", {31'h0, dout_valid}, 32'h0);
    check("ovf_sticky", {31'h0, overflow}, 32'h1);
    clr_ovf = 1'b1;
    send_bit(1'b0, 1'b0);
    clr_ovf = 1'b0;
    check("ovf_cleared", {31'h0, overflow}, 32'h0);

    // Test 5: full FIFO, push and pop on the same edge.
    $display("test5 full push+pop");
    dout_ready = 1'b0;
    expect_frame(32'h11223344);
    expect_frame(32'h55667788);
    send_sync(1'b0);
    send_words(32'h11223344, 1'b0, 1'b0);
    send_sync(1'b0);
    for (int i = 7; i >= 1; i--) send_bit(1'(8'h55 >> i), 1'b1);
    dout_ready = 1'b1;
    send_bit(1'b1, 1'b1);
    check("full_pushpop_ovf", {31'h0, overflow}, 32'h0);
    check("full_pushpop_head", {24'h0, dout}, 32'h22);
    send_byte(8'h66, 1'b0);
    send_byte(8'h77, 1'b0);
    send_byte(8'h88, 1'b0);
    wait_drain(20);
    check("full_pushpop_ovf_end", {31'h0, overflow}, 32'h0);

    // Test 6: asynchronous reset mid-word with two words buffered.
    $display("test6 async reset");
    dout_ready = 1'b0;
    send_sync(1'b0);
    send_byte(8'hAA, 1'b0);
    send_byte(8'hBB, 1'b0);
    send_bit(1'b1, 1'b1);
    send_bit(1'b1, 1'b1);
    send_bit(1'b0, 1'b1);
    check("pre_rst_valid", {31'h0, dout_valid}, 32'h1);
    en = 1'b0;
    #2;
    rst_n = 1'b0;
    #1;
    check("arst_dout", {24'h0, dout}, 32'h0);
    check("arst_valid", {31'h0, dout_valid}, 32'h0);
    check("arst_locked", {31'h0, locked}, 32'h0);
    @(posedge clk);
    #3;
    rst_n = 1'b1;
    @(posedge clk);
    #1;
    dout_ready = 1'b1;
    expect_frame(32'hC33C5A0F);
    send_sync(1'b0);
    send_words(32'hC33C5A0F, 1'b0, 1'b1);
    wait_drain(10);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
